fphub_div_sequencer: RTL and testbench
======================================

FPHUB_DIV_SEQUENCER -- requirements
Module: fphub_div_sequencer

Interface
REQ-001 SHALL have parameter M, default 23, mantissa width.
REQ-002 SHALL have parameter E, default 8, exponent width; operand width W = M+E+1.
REQ-003 SHALL have parameter DEPTH, default 4, request FIFO entries (power of two, >=2).
REQ-004 SHALL have parameter TAG_W, default 4, request tag width.
REQ-005 SHALL have parameter TIMEOUT, default 40, maximum WAIT cycles (>= divider iterations + 3).
REQ-006 Ports: clk  in  1  clock; rst  in  1  reset, asynchronous, active-high.
REQ-007 Ports: in_valid  in  1  request valid; in_ready  out  1  FIFO not full; in_x, in_d  in  W  HUB dividend/divisor; in_tag  in  TAG_W  request tag.
REQ-008 Ports: out_valid  out  1  result valid; out_ready  in  1  consumer accept; out_res  out  W  quotient; out_tag  out  TAG_W; out_special  out  1  divider flagged special case; out_err  out  1  timeout.
REQ-009 Ports: div_start  out  1; div_x, div_d  out  W; div_res  in  W; div_finish  in  1; div_special  in  1 (divider's combinational special-case flag).
REQ-010 Ports: busy  out  1  high when not IDLE or FIFO non-empty.

Function
REQ-011 FIFO push SHALL occur on in_valid && in_ready; in_ready = !full; no bypass; a push SHALL never occur when full.
REQ-012 FSM states SHALL be IDLE, ISSUE, WAIT, HOLD; exactly one divide outstanding.
REQ-013 IDLE -> ISSUE on the next edge when FIFO non-empty; otherwise remain in IDLE.
REQ-014 In ISSUE, div_start SHALL be 1 for exactly one cycle with div_x/div_d = FIFO head; head popped and tag latched at the end of that cycle; next state WAIT.
REQ-015 div_special SHALL be sampled during the ISSUE cycle into a flag later presented as out_special.
REQ-016 div_start SHALL be 0 in all states other than ISSUE; div_x/div_d SHALL hold the last-issued operands outside ISSUE.
REQ-017 In WAIT, a counter SHALL increment each cycle; on div_finish=1, div_res SHALL be captured into out_res, out_err=0, next state HOLD.
REQ-018 If the counter reaches TIMEOUT without div_finish, out_res = {sign of x XOR sign of d, all zeros}, out_err=1, next state HOLD.
REQ-019 div_finish while not in WAIT SHALL be ignored.
REQ-020 In HOLD, out_valid=1 and out_res/out_tag/out_special/out_err SHALL be stable until out_valid && out_ready; then -> IDLE.
REQ-021 Pushes SHALL continue to be accepted in every state while not full; a push and a pop in the same cycle SHALL leave the occupancy unchanged.
REQ-022 Results SHALL leave in request order; minimum latency push-to-out_valid = 3 cycles + divider latency.

Reset
REQ-023 On rst: state IDLE, FIFO empty (pointers 0), WAIT counter 0.
REQ-024 On rst: in_ready=1, out_valid=0, div_start=0, out_res/out_tag/out_special/out_err/div_x/div_d=0, busy=0.
REQ-025 Reset mid-operation SHALL discard queued and in-flight requests; a div_finish arriving after reset SHALL be ignored.

Structure
REQ-026 The state enum and the W width constant SHALL be placed in a shared package fphub_div_pkg.
REQ-027 The FIFO SHALL be a separate sub-module fphub_req_fifo (DEPTH, data = 2W+TAG_W); the FSM and capture logic SHALL be in the top module.
REQ-028 The divider SHALL NOT be instantiated inside this block; it SHALL be connected at the next level up.

Verification
REQ-029 Single request, stub divider finishing 33 cycles after start with div_res=32'h40400000, tag 3 -> one out_valid with out_res=32'h40400000, out_tag=3, out_err=0.
REQ-030 Five back-to-back pushes, DEPTH=4, with the divider stalled -> the fifth push is accepted only after the first pop; results return in tag order 0..4.
REQ-031 Special case: stub asserts div_special during start, finish on the next cycle -> out_special=1, out_valid 3 cycles after push.
REQ-032 Stub never finishes, x sign=1, d sign=0 -> after TIMEOUT cycles in WAIT, out_err=1, out_res=32'h80000000.
REQ-033 out_ready held 0 for 10 cycles in HOLD -> outputs stable, no new div_start; out_ready=1 -> next issue follows.
REQ-034 rst asserted during WAIT with 2 queued requests -> all outputs return to reset values, a late div_finish produces no out_valid, and in_ready=1.

Source files
------------

// File: rtl/fphub_div_pkg.sv
// Shared types and width constants for the HUB divide sequencer slice.
package fphub_div_pkg;

  localparam int M_DEF = 23;
  localparam int E_DEF = 8;
  localparam int W     = M_DEF + E_DEF + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } div_state_e;

  function automatic int op_width(input int m, input int e);
    return m + e + 1;
  endfunction

endpackage

// File: rtl/fphub_div_sequencer_if.sv
// Request, result and divider-side signal bundle of the divide sequencer.
interface fphub_div_sequencer_if #(
  parameter int W     = fphub_div_pkg::W,
  parameter int TAG_W = 4
);

  // Handshakes: a request transfers on in_valid && in_ready, a result on
  // out_valid && out_ready; the sender holds its payload stable until then.
  // div_start is a one-cycle pulse, div_finish a one-cycle completion strobe.
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_x;
  logic [W-1:0]     in_d;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_res;
  logic [TAG_W-1:0] out_tag;
  logic             out_special;
  logic             out_err;

  logic             div_start;
  logic [W-1:0]     div_x;
  logic [W-1:0]     div_d;
  logic [W-1:0]     div_res;
  logic             div_finish;
  logic             div_special;

  modport slave (
    input  in_valid, in_x, in_d, in_tag, out_ready,
           div_res, div_finish, div_special,
    output in_ready, out_valid, out_res, out_tag, out_special, out_err,
           div_start, div_x, div_d
  );

  modport master (
    output in_valid, in_x, in_d, in_tag, out_ready,
           div_res, div_finish, div_special,
    input  in_ready, out_valid, out_res, out_tag, out_special, out_err,
           div_start, div_x, div_d
  );

endinterface

// File: rtl/fphub_req_fifo.sv
// Request FIFO: power-of-two depth, pointer-with-wrap-bit full/empty, no bypass.
module fphub_req_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 68
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign empty = (wr_ptr == rd_ptr);
  // Same slot index with differing wrap bits means the writer lapped the reader.
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/fphub_div_sequencer.sv
// Queues HUB divide requests and runs them one at a time through an external
// iterative divider, returning tagged results in order with a timeout fallback.
module fphub_div_sequencer
  import fphub_div_pkg::*;
#(
  parameter int M       = 23,
  parameter int E       = 8,
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 40
) (
  input  logic                  clk,
  input  logic                  rst,
  fphub_div_sequencer_if.slave  bus,
  output logic                  busy,
  output div_state_e            dbg_state
);

  localparam int OPW   = op_width(M, E);
  localparam int DW    = 2 * OPW + TAG_W;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  div_state_e       state;
  div_state_e       state_nxt;

  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [DW-1:0]    fifo_wdata;
  logic [DW-1:0]    fifo_rdata;

  logic [OPW-1:0]   head_x;
  logic [OPW-1:0]   head_d;
  logic [TAG_W-1:0] head_tag;

  logic [OPW-1:0]   x_q;
  logic [OPW-1:0]   d_q;
  logic [TAG_W-1:0] tag_q;
  logic             special_q;
  logic [OPW-1:0]   res_q;
  logic             err_q;
  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_hit;

  assign fifo_wdata = {bus.in_x, bus.in_d, bus.in_tag};
  assign fifo_push  = bus.in_valid && !fifo_full;
  assign fifo_pop   = (state == ST_ISSUE);
  assign {head_x, head_d, head_tag} = fifo_rdata;

  fphub_req_fifo #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_req_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // The last WAIT cycle is the one where the counter still reads TIMEOUT-1.
  assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (!fifo_empty) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT:  if (bus.div_finish || timeout_hit) state_nxt = ST_HOLD;
      ST_HOLD:  if (bus.out_ready) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q       <= '0;
      d_q       <= '0;
      tag_q     <= '0;
      special_q <= 1'b0;
      res_q     <= '0;
      err_q     <= 1'b0;
      wait_cnt  <= '0;
    end else begin
      case (state)
        ST_ISSUE: begin
          x_q       <= head_x;
          d_q       <= head_d;
          tag_q     <= head_tag;
          special_q <= bus.div_special;
          wait_cnt  <= '0;
        end
        ST_WAIT: begin
          wait_cnt <= wait_cnt + CNT_W'(1);
          if (bus.div_finish) begin
            res_q <= bus.div_res;
            err_q <= 1'b0;
          end else if (timeout_hit) begin
            // Fallback is a signed zero carrying the quotient's sign.
            res_q <= {x_q[OPW-1] ^ d_q[OPW-1], {(OPW-1){1'b0}}};
            err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Operands are driven from the FIFO head while issuing, then held.
  assign bus.div_start   = (state == ST_ISSUE);
  assign bus.div_x       = (state == ST_ISSUE) ? head_x : x_q;
  assign bus.div_d       = (state == ST_ISSUE) ? head_d : d_q;

  assign bus.in_ready    = !fifo_full;
  assign bus.out_valid   = (state == ST_HOLD);
  assign bus.out_res     = res_q;
  assign bus.out_tag     = tag_q;
  assign bus.out_special = special_q;
  assign bus.out_err     = err_q;

  assign busy      = (state != ST_IDLE) || !fifo_empty;
  assign dbg_state = state;

endmodule

// File: tb/tb_fphub_div_sequencer.sv
// Bench for fphub_div_sequencer: stub divider, scoreboard queue, directed and random traffic.
module tb_fphub_div_sequencer;
  import fphub_div_pkg::*;

  localparam int M       = 23;
  localparam int E       = 8;
  localparam int WD      = 32;
  localparam int DEPTH   = 4;
  localparam int TAG_W   = 4;
  localparam int TIMEOUT = 40;
  localparam int EXP_W   = WD + TAG_W + 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       busy;
  div_state_e dbg_state;

  fphub_div_sequencer_if #(.W(WD), .TAG_W(TAG_W)) bus ();

  fphub_div_sequencer #(
    .M(M), .E(E), .DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [EXP_W-1:0] exp_q[$];
  int               stub_lat_q[$];
  logic [WD-1:0]    stub_res_q[$];

  int checks = 0;
  int passes = 0;
  int last_push_cyc = 0;
  int start_cyc = 0;
  int valid_cyc = 0;
  int start_cnt = 0;
  int valid_events = 0;
  bit rand_ready = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Divider stub: special flag is combinational on the divisor (zero magnitude).
  assign bus.div_special = (bus.div_d[WD-2:0] == '0);

  initial begin
    int            stub_cnt;
    bit            stub_active;
    logic [WD-1:0] stub_cur_res;
    stub_cnt = 0;
    stub_active = 0;
    stub_cur_res = '0;
    bus.div_finish = 1'b0;
    bus.div_res = '0;
    forever begin
      @(posedge clk); #1;
      bus.div_finish = 1'b0;
      if (stub_active) begin
        stub_cnt--;
        if (stub_cnt == 0) begin
          bus.div_finish = 1'b1;
          bus.div_res = stub_cur_res;
          stub_active = 0;
        end
      end
      @(negedge clk);
      if (!rst && bus.div_start && stub_lat_q.size() > 0) begin
        stub_cnt = stub_lat_q.pop_front();
        stub_cur_res = stub_res_q.pop_front();
        stub_active = (stub_cnt != 0);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- reference model + driver ----------------
  // lat = cycles after div_start until div_finish; 0 means the divider never answers.
  function automatic logic [EXP_W-1:0] model(input logic [WD-1:0] x, input logic [WD-1:0] d,
                                             input logic [TAG_W-1:0] tag, input int lat,
                                             input logic [WD-1:0] res);
    logic          timed_out;
    logic [WD-1:0] q;
    logic          special;
    timed_out = (lat == 0) || (lat > TIMEOUT);
    q = timed_out ? ({x[WD-1] ^ d[WD-1], {(WD-1){1'b0}}}) : res;
    special = (d[WD-2:0] == '0);
    return {q, tag, special, timed_out};
  endfunction

  task automatic push_req(input logic [WD-1:0] x, input logic [WD-1:0] d,
                          input logic [TAG_W-1:0] tag, input int lat, input logic [WD-1:0] res);
    int waited;
    bit accepted;
    waited = 0;
    accepted = 0;
    bus.in_valid = 1'b1;
    bus.in_x = x;
    bus.in_d = d;
    bus.in_tag = tag;
    while (!accepted && waited < 300) begin
      @(negedge clk);
      if (bus.in_ready) accepted = 1;
      else waited++;
    end
    if (!accepted) check("push_accept_timeout", 64'(waited), 0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    last_push_cyc = cyc;
    exp_q.push_back(model(x, d, tag, lat, res));
    stub_lat_q.push_back(lat);
    stub_res_q.push_back(res);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, 64'(exp_q.size()), 0);
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [EXP_W-1:0] e;
    logic [EXP_W-1:0] prev_out;
    logic             prev_valid;
    logic             prev_acc;
    prev_valid = 0;
    prev_acc = 0;
    prev_out = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_valid = 0;
        prev_acc = 0;
      end else begin
        if (bus.div_start) begin
          start_cnt++;
          start_cyc = cyc;
        end
        if (bus.out_valid) begin
          valid_events++;
          if (!prev_valid) valid_cyc = cyc;
          if (prev_valid && !prev_acc) begin
            check("hold_stable", {bus.out_res, bus.out_tag, bus.out_special, bus.out_err}, prev_out);
            check("hold_no_start", bus.div_start, 0);
          end
          if (bus.out_ready) begin
            if (exp_q.size() == 0) check("unexpected_out_valid", 64'(exp_q.size()), 1);
            else begin
              e = exp_q.pop_front();
              check("out_res", bus.out_res, e[EXP_W-1 -: WD]);
              check("out_tag", bus.out_tag, e[TAG_W+1:2]);
              check("out_special", bus.out_special, e[1]);
              check("out_err", bus.out_err, e[0]);
            end
          end
        end
        prev_valid = bus.out_valid;
        prev_acc = bus.out_valid && bus.out_ready;
        prev_out = {bus.out_res, bus.out_tag, bus.out_special, bus.out_err};
      end
    end
  end

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_in_ready"}, bus.in_ready, 1);
    check({pfx, "_out_valid"}, bus.out_valid, 0);
    check({pfx, "_div_start"}, bus.div_start, 0);
    check({pfx, "_out_res"}, bus.out_res, 0);
    check({pfx, "_out_tag"}, bus.out_tag, 0);
    check({pfx, "_out_special"}, bus.out_special, 0);
    check({pfx, "_out_err"}, bus.out_err, 0);
    check({pfx, "_div_x"}, bus.div_x, 0);
    check({pfx, "_div_d"}, bus.div_d, 0);
    check({pfx, "_busy"}, busy, 0);
    check({pfx, "_state"}, 64'(dbg_state), 64'(ST_IDLE));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int s;
    int v;
    int n;
    bus.in_valid = 1'b0;
    bus.in_x = '0;
    bus.in_d = '0;
    bus.in_tag = '0;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Single request, divider answers 33 cycles after start.
    push_req(32'h40c00000, 32'h40000000, 4'd3, 33, 32'h40400000);
    wait_drain("single_drained");

    // Divide by zero: special flag, one-cycle divider, minimum latency.
    push_req(32'h3f800000, 32'h00000000, 4'd5, 1, 32'h7f800000);
    wait_drain("special_drained");
    check("special_latency", 64'(valid_cyc - last_push_cyc), 3);

    // Divider never answers: negative/positive -> negative zero after TIMEOUT WAIT cycles.
    push_req(32'hbf800000, 32'h40000000, 4'd6, 0, 32'h12345678);
    wait_drain("timeout_drained");
    check("timeout_latency", 64'(valid_cyc - start_cyc), 64'(TIMEOUT + 1));
    // Finish on the very last WAIT cycle still wins; one cycle later is a timeout.
    push_req(32'h40800000, 32'h40000000, 4'd7, TIMEOUT, 32'h40000000);
    push_req(32'h3f800000, 32'hc0000000, 4'd8, TIMEOUT + 1, 32'h0badf00d);
    wait_drain("timeout_edge_drained");

    // Five back-to-back pushes with a slow divider fill the FIFO.
    for (int i = 0; i < 5; i++) push_req($urandom, $urandom | 32'h1, 4'(i), 20, $urandom);
    @(negedge clk);
    check("full_in_ready", bus.in_ready, 0);
    @(posedge clk); #1;
    push_req(32'h40000000, 32'h3f800000, 4'd5, 2, 32'h40000000);
    check("push_after_pop", 64'(last_push_cyc - start_cyc), 2);
    wait_drain("fill_drained");

    // Consumer stalls in HOLD.
    bus.out_ready = 1'b0;
    push_req(32'h41000000, 32'h40000000, 4'd9, 3, 32'h40800000);
    push_req(32'h41200000, 32'h40a00000, 4'd10, 3, 32'h40000000);
    n = 0;
    while (!bus.out_valid && n < 100) begin @(negedge clk); n++; end
    check("hold_reached", bus.out_valid, 1);
    s = start_cnt;
    repeat (10) @(negedge clk);
    check("hold_no_issue", 64'(start_cnt), 64'(s));
    check("hold_still_valid", bus.out_valid, 1);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    wait_drain("hold_drained");
    check("next_issue", 64'(start_cnt), 64'(s + 1));

    // Reset while one divide is in WAIT and two are queued.
    push_req(32'h40000000, 32'h40000000, 4'd1, 10, 32'h3f800000);
    push_req(32'h40400000, 32'h40000000, 4'd2, 10, 32'h3fc00000);
    push_req(32'h40800000, 32'h40000000, 4'd3, 10, 32'h40000000);
    repeat (3) @(posedge clk);
    #1;
    check("mid_wait_state", 64'(dbg_state), 64'(ST_WAIT));
    rst = 1'b1;
    exp_q.delete();
    stub_lat_q.delete();
    stub_res_q.delete();
    #1;
    check_reset_outputs("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    v = valid_events;
    repeat (20) @(posedge clk);
    #1;
    check("late_finish_ignored", 64'(valid_events), 64'(v));
    check("post_rst_in_ready", bus.in_ready, 1);
    check("post_rst_busy", busy, 0);

    // Randomized traffic with a randomly stalling consumer.
    rand_ready = 1;
    for (int i = 0; i < 40; i++) begin
      logic [WD-1:0] x;
      logic [WD-1:0] d;
      int r;
      int lat;
      x = $urandom;
      d = ($urandom_range(0, 4) == 0) ? {1'($urandom_range(0, 1)), 31'b0} : $urandom;
      r = $urandom_range(0, 11);
      lat = (r == 0) ? 0 : (r == 1) ? TIMEOUT : (r == 2) ? TIMEOUT + 1 : $urandom_range(1, 12);
      push_req(x, d, 4'(i), lat, $urandom);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    wait_drain("random_drained");
    rand_ready = 0;
    @(posedge clk); #1;
    bus.out_ready = 1'b1;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got time %0t, expected finish", $time);
    $fatal(1);
  end

endmodule
